rc5_decrypt: RTL and testbench
==============================

# rc5_decrypt

Iterative RC5-16 decryption core (16-bit words, 32-bit block, 1–16 rounds), the inverse of the team's RC5 encryption datapath. It holds a 34-entry subkey table, loaded one word at a time by an external key-expansion/loader block. It processes one round per clock and returns plaintext in the same word packing that the encryptor uses for its output. It sits beside the encryptor in the accelerator and shares its clock, its reset and its block format.

## Interface
- No parameters; word size (16), table depth (34) and max rounds (16) are fixed.
- clk  in  1  sole clock, all state updates on rising edge
- rst  in  1  reset, synchronous, active-low
- start  in  1  request decryption; accepted only when busy=0
- num_rounds  in  5  round count r, sampled with accepted start; values >16 treated as 16
- d_in  in  32  ciphertext, sampled with accepted start; A=d_in[15:0], B=d_in[31:16]
- sk_we  in  1  subkey write enable
- sk_addr  in  6  subkey index 0–33; 34–63 ignored
- sk_data  in  16  subkey value
- d_out  out  32  plaintext {B,A}; registered, holds until next result
- done  out  1  one-cycle pulse, d_out valid
- busy  out  1  high from accepted start until result written

## Operation
- Reset (rst=0 at an edge): state IDLE; A, B, round counter, d_out=0; done=0; busy=0; all 34 subkeys=0. Reset mid-operation aborts the operation with no done pulse.
- Subkey writes: when sk_we=1, busy=0 and sk_addr<34, S[sk_addr] <= sk_data. Writes while busy=1 are dropped. A write and an accepted start in the same cycle are both performed; the operation that starts uses the old value of that entry.
- States: IDLE, ROUND, FINAL.
- IDLE:
  - On start=1: A<=d_in[15:0]; B<=d_in[31:16]; i<=min(num_rounds,16); busy<=1.
  - Next state is ROUND if r≥1, or FINAL if r=0.
- ROUND (index i, counting r down to 1), computed in a single cycle:
  - B' = ((B − S[2i+1]) >>> A[3:0]) ^ A
  - A' = ((A − S[2i]) >>> B'[3:0]) ^ B'
  - A is rotated by the new B' value.
  - Registers: A<=A', B<=B', i<=i−1.
  - Next state is FINAL when i=1, otherwise ROUND.
- FINAL: d_out <= {B − S[1], A − S[0]}; done<=1 for one cycle; busy<=0; go to IDLE.
- Arithmetic: all subtractions are mod 2^16. Rotations are right-rotations by the low 4 bits of the operand only; bits [15:4] are ignored.
- start while busy=1 is ignored and has no effect on the running operation.
- num_rounds and d_in changes after acceptance have no effect.

## Timing
- Call the edge that accepts start edge 0.
- Round k (k=1..r) is performed at edge k.
- FINAL writes d_out at edge r+1; done=1 and the new d_out are visible during the cycle after edge r+1.
- Latency from accept to done is r+1 cycles: r=0 gives 1 cycle, r=16 gives 17 cycles.
- busy=1 for cycles after edges 0..r and returns to 0 together with done=1.
- Back-to-back operation: start may be asserted in the cycle in which done=1 and is accepted at that edge. Throughput is one block per r+2 cycles.
- d_out changes only at the FINAL edge and otherwise keeps the last result, or 0 after reset.

## Test plan
- Reset values: hold rst=0 for 2 edges, then release. Expect d_out=0, done=0, busy=0. Then run r=0 with d_in=0x1234_5678: expect d_out=0x1234_5678, which confirms the subkeys cleared to 0.
- r=0 whitening only: set S0=0x1234, S1=0x0001; start with d_in=0x5678_9ABC. Expect done one cycle after accept and d_out=0x5677_8888.
- Single round: all subkeys 0; start with r=1 and d_in=0x0003_0001. Expect done 2 cycles after accept and d_out=0x8000_8001.
- Rotation masking and clamping: all subkeys 0; start with r=31 and d_in=0xFFF3_FFF1. Expect busy for exactly 17 cycles, done at latency 17, and d_out equal to the 16-round model result with shift amounts taken mod 16.
- Protocol edges:
  - Start pulses while busy do not restart the operation or change its result.
  - sk_we while busy leaves the table unchanged; read back by a later r=0 run.
  - Start asserted in the done cycle is accepted; two results in r+2-cycle cadence.
  - rst=0 at round 5 of 12 gives no done, and all outputs are 0 after that edge.
- Round-trip: load random 34-word tables and encrypt 1000 random blocks with a software RC5-16 model at random r in 0–16. Decrypt on the DUT and expect each d_out to equal the original plaintext with latency r+1.

Source files
------------

// File: rtl/rc5_decrypt_if.sv
// rtl/rc5_decrypt_if.sv - command, subkey-load and result signals of the RC5-16 decryptor
interface rc5_decrypt_if;
    logic        start;
    logic [4:0]  num_rounds;
    logic [31:0] d_in;
    logic        sk_we;
    logic [5:0]  sk_addr;
    logic [15:0] sk_data;
    logic [31:0] d_out;
    logic        done;
    logic        busy;

    modport master (
        output start, num_rounds, d_in, sk_we, sk_addr, sk_data,
        input  d_out, done, busy
    );

    modport slave (
        input  start, num_rounds, d_in, sk_we, sk_addr, sk_data,
        output d_out, done, busy
    );
endinterface

// File: rtl/rc5_decrypt.sv
// rtl/rc5_decrypt.sv - iterative RC5-16 decryption core, one round per clock, 34-word subkey table
module rc5_decrypt (
    input  logic         clk,
    input  logic         rst,
    rc5_decrypt_if.slave bus
);

    typedef enum logic [1:0] {IDLE, ROUND, FINAL} state_t;

    state_t      state_q, state_d;
    logic [15:0] a_q, a_d;
    logic [15:0] b_q, b_d;
    logic [4:0]  i_q, i_d;
    logic [31:0] d_out_q, d_out_d;
    logic        done_q, done_d;
    logic [15:0] sk_q [34];
    logic [15:0] sk_d [34];

    // A write that lands with an accepted start is parked here and committed at FINAL,
    // so the operation that starts still sees the old table entry.
    logic        pend_q, pend_d;
    logic [5:0]  pend_addr_q, pend_addr_d;
    logic [15:0] pend_data_q, pend_data_d;

    logic        accept;
    logic        wr_ok;
    logic [4:0]  r_clamp;
    logic [5:0]  idx_even;
    logic [5:0]  idx_odd;
    logic [15:0] s_even;
    logic [15:0] s_odd;
    logic [15:0] a_new;
    logic [15:0] b_new;

    function automatic logic [15:0] rotr16(input logic [15:0] x, input logic [3:0] n);
        logic [31:0] t;
        t = {x, x} >> n;
        return t[15:0];
    endfunction

    assign accept   = (state_q == IDLE) && bus.start;
    assign wr_ok    = (state_q == IDLE) && bus.sk_we && (bus.sk_addr < 6'd34);
    assign r_clamp  = (bus.num_rounds > 5'd16) ? 5'd16 : bus.num_rounds;
    assign idx_even = {i_q, 1'b0};
    assign idx_odd  = {i_q, 1'b1};
    assign s_even   = sk_q[idx_even];
    assign s_odd    = sk_q[idx_odd];
    assign b_new    = rotr16(b_q - s_odd, a_q[3:0]) ^ a_q;
    assign a_new    = rotr16(a_q - s_even, b_new[3:0]) ^ b_new;

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        i_d         = i_q;
        d_out_d     = d_out_q;
        done_d      = 1'b0;
        sk_d        = sk_q;
        pend_d      = pend_q;
        pend_addr_d = pend_addr_q;
        pend_data_d = pend_data_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    a_d     = bus.d_in[15:0];
                    b_d     = bus.d_in[31:16];
                    i_d     = r_clamp;
                    state_d = (r_clamp != 5'd0) ? ROUND : FINAL;
                    if (wr_ok) begin
                        pend_d      = 1'b1;
                        pend_addr_d = bus.sk_addr;
                        pend_data_d = bus.sk_data;
                    end
                end else if (wr_ok) begin
                    sk_d[bus.sk_addr] = bus.sk_data;
                end
            end
            ROUND: begin
                a_d = a_new;
                b_d = b_new;
                i_d = i_q - 5'd1;
                if (i_q == 5'd1) begin
                    state_d = FINAL;
                end
            end
            FINAL: begin
                d_out_d = {b_q - sk_q[1], a_q - sk_q[0]};
                done_d  = 1'b1;
                state_d = IDLE;
                if (pend_q) begin
                    sk_d[pend_addr_q] = pend_data_q;
                    pend_d            = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            i_q         <= '0;
            d_out_q     <= '0;
            done_q      <= 1'b0;
            pend_q      <= 1'b0;
            pend_addr_q <= '0;
            pend_data_q <= '0;
            for (int k = 0; k < 34; k++) begin
                sk_q[k] <= '0;
            end
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            i_q         <= i_d;
            d_out_q     <= d_out_d;
            done_q      <= done_d;
            pend_q      <= pend_d;
            pend_addr_q <= pend_addr_d;
            pend_data_q <= pend_data_d;
            sk_q        <= sk_d;
        end
    end

    assign bus.d_out = d_out_q;
    assign bus.done  = done_q;
    assign bus.busy  = (state_q != IDLE);

endmodule

// File: tb/tb_rc5_decrypt.sv
// tb/tb_rc5_decrypt.sv - randomized round-trip bench for rc5_decrypt against an RC5-16 software model
module tb_rc5_decrypt;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    rc5_decrypt_if bus ();

    rc5_decrypt dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int done_cyc = 0;
    always @(posedge clk) cyc++;

    logic [15:0] sk_m [34];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h", tag, got, exp);
    endtask

    function automatic logic [15:0] rotl16(input logic [15:0] x, input int n);
        int s;
        logic [31:0] w;
        s = n & 15;
        w = {16'h0, x};
        w = (w << s) | (w >> (16 - s));
        return w[15:0];
    endfunction

    function automatic logic [15:0] rotr16(input logic [15:0] x, input int n);
        return rotl16(x, 16 - (n & 15));
    endfunction

    function automatic logic [31:0] enc(input logic [31:0] pt, input int r);
        logic [15:0] a, b;
        a = pt[15:0] + sk_m[0];
        b = pt[31:16] + sk_m[1];
        for (int i = 1; i <= r; i++) begin
            a = rotl16(a ^ b, int'(b)) + sk_m[2*i];
            b = rotl16(b ^ a, int'(a)) + sk_m[2*i+1];
        end
        return {b, a};
    endfunction

    function automatic logic [31:0] dec(input logic [31:0] ct, input int rr);
        logic [15:0] a, b;
        int r;
        r = (rr > 16) ? 16 : rr;
        a = ct[15:0];
        b = ct[31:16];
        for (int i = r; i >= 1; i--) begin
            b = rotr16(b - sk_m[2*i+1], int'(a)) ^ a;
            a = rotr16(a - sk_m[2*i], int'(b)) ^ b;
        end
        return {b - sk_m[1], a - sk_m[0]};
    endfunction

    task automatic write_sk(input logic [5:0] addr, input logic [15:0] data);
        bus.sk_we   = 1'b1;
        bus.sk_addr = addr;
        bus.sk_data = data;
        @(posedge clk);
        @(negedge clk);
        bus.sk_we = 1'b0;
        if (addr < 6'd34) sk_m[addr] = data;
    endtask

    task automatic load_random_table();
        for (int k = 0; k < 34; k++) write_sk(6'(k), 16'($urandom));
        write_sk(6'($urandom_range(34, 63)), 16'($urandom));
    endtask

    // Called at a negedge with the core idle (or in its done cycle); returns at the done cycle.
    task automatic run_op(input logic [4:0] nr, input logic [31:0] din, input bit noise,
                          input bit wr_en, input logic [5:0] wa, input logic [15:0] wd,
                          output logic [31:0] got, output int lat, output int busy_cyc);
        bus.start      = 1'b1;
        bus.num_rounds = nr;
        bus.d_in       = din;
        bus.sk_we      = wr_en;
        bus.sk_addr    = wa;
        bus.sk_data    = wd;
        @(posedge clk);
        @(negedge clk);
        bus.start      = 1'b0;
        bus.sk_we      = 1'b0;
        bus.d_in       = $urandom;
        bus.num_rounds = 5'($urandom);
        lat      = 0;
        busy_cyc = 0;
        if (bus.busy) busy_cyc++;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (bus.done) break;
            if (bus.busy) busy_cyc++;
            if (noise) begin
                bus.start      = 1'($urandom);
                bus.d_in       = $urandom;
                bus.num_rounds = 5'($urandom);
                bus.sk_we      = 1'($urandom);
                bus.sk_addr    = 6'($urandom_range(0, 1));
                bus.sk_data    = 16'($urandom);
            end
        end
        bus.start = 1'b0;
        bus.sk_we = 1'b0;
        done_cyc  = cyc;
        check("done_seen", 32'(bus.done), 32'd1);
        got = bus.d_out;
    endtask

    logic [31:0] got, pt, ct, din;
    logic [15:0] new_s0;
    int lat, bcyc, t1, r, seen_done;
    logic [4:0] nr;

    initial begin
        bus.start = 0; bus.num_rounds = 0; bus.d_in = 0;
        bus.sk_we = 0; bus.sk_addr = 0; bus.sk_data = 0;
        for (int k = 0; k < 34; k++) sk_m[k] = 16'h0;

        rst = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("rst_dout", bus.d_out, 32'h0);
        check("rst_done", 32'(bus.done), 32'h0);
        check("rst_busy", 32'(bus.busy), 32'h0);

        run_op(5'd0, 32'h1234_5678, 0, 0, 0, 0, got, lat, bcyc);
        check("rst_table", got, 32'h1234_5678);
        check("rst_lat", lat, 1);

        write_sk(6'd0, 16'h1234);
        write_sk(6'd1, 16'h0001);
        run_op(5'd0, 32'h5678_9ABC, 0, 0, 0, 0, got, lat, bcyc);
        check("whiten", got, 32'h5677_8888);
        check("whiten_lat", lat, 1);

        write_sk(6'd0, 16'h0);
        write_sk(6'd1, 16'h0);
        run_op(5'd1, 32'h0003_0001, 0, 0, 0, 0, got, lat, bcyc);
        check("one_round", got, 32'h8000_8001);
        check("one_round_lat", lat, 2);

        run_op(5'd31, 32'hFFF3_FFF1, 0, 0, 0, 0, got, lat, bcyc);
        check("clamp", got, dec(32'hFFF3_FFF1, 16));
        check("clamp_lat", lat, 17);
        check("clamp_busy", bcyc, 17);

        load_random_table();
        pt = $urandom;
        ct = enc(pt, 8);
        run_op(5'd8, ct, 1, 0, 0, 0, got, lat, bcyc);
        check("noise_result", got, pt);
        check("noise_lat", lat, 9);
        din = $urandom;
        run_op(5'd0, din, 0, 0, 0, 0, got, lat, bcyc);
        check("busy_wr_drop", got, dec(din, 0));

        new_s0 = sk_m[0] ^ 16'h5A5A;
        run_op(5'd0, din, 0, 1, 6'd0, new_s0, got, lat, bcyc);
        check("wr_start_old", got, dec(din, 0));
        sk_m[0] = new_s0;
        run_op(5'd0, din, 0, 0, 0, 0, got, lat, bcyc);
        check("wr_start_new", got, dec(din, 0));

        pt = $urandom;
        run_op(5'd5, enc(pt, 5), 0, 0, 0, 0, got, lat, bcyc);
        check("b2b_first", got, pt);
        t1 = done_cyc;
        pt = $urandom;
        run_op(5'd5, enc(pt, 5), 0, 0, 0, 0, got, lat, bcyc);
        check("b2b_second", got, pt);
        check("b2b_cadence", done_cyc - t1, 7);

        bus.start      = 1'b1;
        bus.num_rounds = 5'd12;
        bus.d_in       = $urandom;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (4) begin
            @(posedge clk);
            @(negedge clk);
        end
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("abort_dout", bus.d_out, 32'h0);
        check("abort_done", 32'(bus.done), 32'h0);
        check("abort_busy", 32'(bus.busy), 32'h0);
        rst = 1'b1;
        seen_done = 0;
        repeat (20) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.done) seen_done++;
        end
        check("abort_no_done", seen_done, 0);
        for (int k = 0; k < 34; k++) sk_m[k] = 16'h0;
        din = $urandom;
        run_op(5'd0, din, 0, 0, 0, 0, got, lat, bcyc);
        check("abort_table", got, din);

        for (int n = 0; n < 1000; n++) begin
            if (n % 100 == 0) load_random_table();
            pt = $urandom;
            r  = $urandom_range(0, 16);
            nr = (r == 16) ? 5'($urandom_range(16, 31)) : 5'(r);
            ct = enc(pt, r);
            run_op(nr, ct, 0, 0, 0, 0, got, lat, bcyc);
            check("roundtrip", got, pt);
            check("roundtrip_lat", lat, r + 1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
